fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/project_types.sv | 25 ++
 rtl/pc_reg.sv | 62 ++++++
 rtl/fetch_unit.sv | 53 +++++
 3 files changed

// File: rtl/project_types.sv
// Shared fetch-path types: PC/instruction words, ROM chip status and fetch FSM state.
package project_types;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] inst_t;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_status_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_RUN  = 1'b1
  } fetch_state_t;

  localparam pc_t PC_INCR          = 32'd4;
  localparam pc_t DEFAULT_RESET_PC = 32'h0000_0000;

  // Instructions are word aligned; redirect addresses drop their byte offset.
  function automatic pc_t word_align(input pc_t addr);
    return addr & ~pc_t'(32'd3);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter, fetch FSM and next-PC selection.
module pc_reg
  import project_types::*;
#(
  parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_flag,
  input  pc_t          branch_target,
  input  logic         flush,
  input  pc_t          flush_pc,
  output chip_status_t rom_ce,
  output pc_t          rom_pc
);

  fetch_state_t state_q, state_d;
  pc_t          pc_q, pc_d;

  // State and PC register; reset drops any pending redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= F_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state and next PC: flush beats stall beats branch beats sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      F_IDLE: begin
        // Enable edge presents RESET_PC itself, not RESET_PC + 4.
        state_d = F_RUN;
        pc_d    = RESET_PC;
      end
      F_RUN: begin
        if (flush) begin
          pc_d = word_align(flush_pc);
        end else if (stall) begin
          pc_d = pc_q;
        end else if (branch_flag) begin
          pc_d = word_align(branch_target);
        end else begin
          pc_d = pc_q + PC_INCR;
        end
      end
    endcase
  end

  // ROM enable follows the FSM state; address comes straight from the PC register.
  always_comb begin
    rom_ce = (state_q == F_RUN) ? CHIP_ENABLE : CHIP_DISABLE;
    rom_pc = pc_q;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation plus the IF/ID pipeline register.
module fetch_unit
  import project_types::*;
#(
  parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_flag,
  input  pc_t          branch_target,
  input  logic         flush,
  input  pc_t          flush_pc,
  output chip_status_t rom_ce,
  output pc_t          rom_pc,
  input  inst_t        rom_inst,
  output pc_t          id_pc,
  output inst_t        id_inst,
  output logic         id_valid
);

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .rom_ce       (rom_ce),
    .rom_pc       (rom_pc)
  );

  // IF/ID register: flush clears, stall holds; a branch does not squash (delay slot).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_pc    <= rom_pc;
      id_inst  <= (rom_ce == CHIP_ENABLE) ? rom_inst : '0;
      id_valid <= (rom_ce == CHIP_ENABLE);
    end
  end

endmodule
